// File: rtl/pwm_irq_event_gen_pkg.sv
// Shared widths and types for the PWM event-to-interrupt stage.
package pwm_irq_event_gen_pkg;

  localparam int N_CH    = 8;
  localparam int PRESC_W = 4;

  typedef logic [PRESC_W-1:0] presc_t;
  typedef logic [N_CH-1:0]    irq_vec_t;

endpackage

// File: rtl/pwm_irq_event_gen_slice.sv
// One channel: rising-edge detect, edge prescaler,
// sticky pending bit and sticky overflow bit.
module irq_chan_slice #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ev_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               clr_i,
  output logic               pend_o,
  output logic               ovf_o
);

  logic               d1_q, d2_q;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               rise;
  logic               tick;

  assign rise = d1_q & ~d2_q & en_i;
  assign tick = rise & (cnt_q >= presc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  // Set beats clear so an event landing on a clear is never lost.
  always_comb begin
    pend_d = tick | (pend_q & ~clr_i);
    ovf_d  = (tick & pend_q & ~clr_i) | (ovf_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q   <= ev_i;
      d2_q   <= ev_i;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      d1_q   <= ev_i;
      d2_q   <= d1_q;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/pwm_irq_event_gen.sv
// Per-channel PWM event levels to sticky prescaled
// interrupt-pending bits for the interrupt matrix.
module pwm_irq_event_gen
  import pwm_irq_event_gen_pkg::*;
#(
  parameter int N_CH    = pwm_irq_event_gen_pkg::N_CH,
  parameter int PRESC_W = pwm_irq_event_gen_pkg::PRESC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         event_in,
  input  logic [N_CH-1:0]         event_en,
  input  logic [N_CH*PRESC_W-1:0] prescale,
  input  logic [N_CH-1:0]         clear_w1c,
  output logic [N_CH-1:0]         pending,
  output logic [N_CH-1:0]         overflow
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    irq_chan_slice #(
      .PRESC_W (PRESC_W)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .ev_i    (event_in[i]),
      .en_i    (event_en[i]),
      .presc_i (prescale[i*PRESC_W +: PRESC_W]),
      .clr_i   (clear_w1c[i]),
      .pend_o  (pending[i]),
      .ovf_o   (overflow[i])
    );
  end

endmodule

// File: tb/tb_pwm_irq_event_gen.sv
// Scoreboard bench: stimulus queues expected pending/overflow
// per cycle, a negedge monitor pops and compares.
module tb_pwm_irq_event_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  event_in;
  logic [7:0]  event_en;
  logic [31:0] prescale;
  logic [7:0]  clear_w1c;
  logic [7:0]  pending;
  logic [7:0]  overflow;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  p;
    logic [7:0]  o;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          stim_done = 1'b0;

  pwm_irq_event_gen dut (
    .clk       (clk),
    .rst       (rst),
    .event_in  (event_in),
    .event_en  (event_en),
    .prescale  (prescale),
    .clear_w1c (clear_w1c),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_st(input logic [7:0] p, input logic [7:0] o,
                           input string nm);
    exp_t e;
    e.cyc = cyc;
    e.p   = p;
    e.o   = o;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input int ch);
    event_in[ch] = 1'b1;
    step(1);
    event_in[ch] = 1'b0;
    step(1);
  endtask

  task automatic set_presc(input int ch, input logic [3:0] v);
    prescale[ch*4 +: 4] = v;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: check missed its cycle (%0d now %0d)",
                   e.nm, e.cyc, cyc);
        end else if (pending !== e.p || overflow !== e.o) begin
          errors++;
          $display("FAIL %s: got pend=%h ovf=%h want pend=%h ovf=%h",
                   e.nm, pending, overflow, e.p, e.o);
        end
      end
      if (stim_done && exp_q.size() == 0) break;
    end
  end

  initial begin
    rst       = 1'b1;
    event_in  = 8'hFF;
    event_en  = 8'hFF;
    prescale  = '0;
    clear_w1c = 8'h00;

    // Reset with levels held high through release
    step(2);
    expect_st(8'h00, 8'h00, "reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      expect_st(8'h00, 8'h00, "held_high");
    end
    event_in = 8'h00;
    step(2);
    expect_st(8'h00, 8'h00, "fall_no_evt");

    // Ch0: latency and W1C
    pulse(0);
    expect_st(8'h01, 8'h00, "ch0_set_E1");
    step(3);
    expect_st(8'h01, 8'h00, "ch0_sticky");
    clear_w1c = 8'h01;
    step(1);
    clear_w1c = 8'h00;
    expect_st(8'h00, 8'h00, "ch0_clear");

    // Ch3: prescale 2, 7 pulses
    set_presc(3, 4'd2);
    for (int k = 1; k <= 7; k++) begin
      pulse(3);
      expect_st((k >= 3) ? 8'h08 : 8'h00,
                (k >= 6) ? 8'h08 : 8'h00, $sformatf("ch3_p%0d", k));
      step(2);
    end
    clear_w1c = 8'h08;
    step(1);
    clear_w1c = 8'h00;
    expect_st(8'h00, 8'h00, "ch3_clear");

    // Ch5: tick coinciding with clear
    pulse(5);
    expect_st(8'h20, 8'h00, "ch5_set");
    event_in[5] = 1'b1;
    step(1);
    clear_w1c = 8'h20;
    step(1);
    clear_w1c   = 8'h00;
    event_in[5] = 1'b0;
    expect_st(8'h20, 8'h00, "ch5_tick_clr");
    step(1);
    expect_st(8'h20, 8'h00, "ch5_hold");
    clear_w1c = 8'h20;
    step(1);
    clear_w1c = 8'h00;
    expect_st(8'h00, 8'h00, "ch5_clear");

    // Ch7: lower prescale below current count
    set_presc(7, 4'd5);
    for (int k = 1; k <= 3; k++) begin
      pulse(7);
      expect_st(8'h00, 8'h00, $sformatf("ch7_cnt%0d", k));
      step(1);
    end
    set_presc(7, 4'd1);
    pulse(7);
    expect_st(8'h80, 8'h00, "ch7_low_tick");
    step(1);
    pulse(7);
    expect_st(8'h80, 8'h00, "ch7_cnt_reset");
    step(1);
    pulse(7);
    expect_st(8'h80, 8'h80, "ch7_ovf");
    clear_w1c = 8'h80;
    step(1);
    clear_w1c = 8'h00;
    expect_st(8'h00, 8'h00, "ch7_clear");

    // Ch2: disable discards partial count, holds pending
    set_presc(2, 4'd3);
    for (int k = 1; k <= 4; k++) begin
      pulse(2);
      step(1);
    end
    expect_st(8'h04, 8'h00, "ch2_first_tick");
    pulse(2);
    step(1);
    pulse(2);
    step(1);
    expect_st(8'h04, 8'h00, "ch2_cnt2");
    event_en[2] = 1'b0;
    event_in[2] = 1'b1;
    step(1);
    expect_st(8'h04, 8'h00, "ch2_dis1");
    event_in[2] = 1'b0;
    step(1);
    expect_st(8'h04, 8'h00, "ch2_dis2");
    step(1);
    expect_st(8'h04, 8'h00, "ch2_dis3");
    event_en[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pulse(2);
      expect_st(8'h04, (k == 4) ? 8'h04 : 8'h00,
                $sformatf("ch2_re%0d", k));
      step(1);
    end

    // Mid-count reset
    pulse(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_st(8'h00, 8'h00, "rst_mid");
    pulse(7);
    expect_st(8'h00, 8'h00, "rst_cnt_gone");

    stim_done = 1'b1;
    step(3);
    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      checks += exp_q.size();
      $display("FAIL drain: %0d checks never compared, want 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
